// File: rtl/multicycle_datapath_pkg.sv
// Shared definitions for the multi-cycle integer datapath: opcodes, formats,
// condition codes, FSM states and the deferred register-write descriptor.
package multicycle_datapath_pkg;

  localparam logic [4:0] OP_BR   = 5'h00;
  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_LD   = 5'h02;
  localparam logic [4:0] OP_ST   = 5'h03;
  localparam logic [4:0] OP_JSR  = 5'h04;
  localparam logic [4:0] OP_AND  = 5'h05;
  localparam logic [4:0] OP_JSRR = 5'h06;
  localparam logic [4:0] OP_MOV  = 5'h07;
  localparam logic [4:0] OP_JMP  = 5'h0C;

  localparam logic [2:0] FMT_IR = 3'b000;
  localparam logic [2:0] FMT_II = 3'b001;

  // Condition code layout is {P,Z,N}
  localparam logic [2:0] CC_N = 3'b001;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b100;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef struct packed {
    logic       en;
    logic [3:0] idx;
    logic       set_cc;
  } rf_wr_t;

endpackage

// File: rtl/multicycle_datapath_alu.sv
// Combinational ALU: ADD/AND/MOV results, memory address, next-PC selection
// and condition-code derivation for the write-back value.
module dp_alu
  import multicycle_datapath_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PC_WIDTH   = 16
) (
  input  logic [4:0]            opcode,
  input  logic [2:0]            fmt,
  input  logic [DATA_WIDTH-1:0] src1_val,
  input  logic [DATA_WIDTH-1:0] src2_val,
  input  logic [15:0]           imm,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic [2:0]            cc,
  input  logic [DATA_WIDTH-1:0] cc_value,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [PC_WIDTH-1:0]   next_pc,
  output logic [2:0]            cc_next
);

  logic [DATA_WIDTH-1:0] imm_ext;
  logic [DATA_WIDTH-1:0] operand_b;
  logic [DATA_WIDTH-1:0] link_val;
  logic [PC_WIDTH-1:0]   imm_pc;
  logic [PC_WIDTH-1:0]   pc_plus4;
  logic [PC_WIDTH-1:0]   br_target;
  logic [PC_WIDTH-1:0]   jmp_target;

  assign imm_ext    = DATA_WIDTH'($signed(imm));
  assign imm_pc     = PC_WIDTH'($signed(imm));
  assign operand_b  = (fmt == FMT_II) ? imm_ext : src2_val;
  assign pc_plus4   = pc + PC_WIDTH'(4);
  assign br_target  = pc_plus4 + (imm_pc << 2);
  // Register jump targets are word aligned regardless of the low bits held
  assign jmp_target = PC_WIDTH'(src1_val) & ~PC_WIDTH'(3);
  assign link_val   = DATA_WIDTH'(pc_plus4);
  assign mem_addr   = src1_val + imm_ext;

  always_comb begin
    result  = '0;
    next_pc = pc_plus4;
    case (opcode)
      OP_ADD:  result = src1_val + operand_b;
      OP_AND:  result = src1_val & operand_b;
      OP_MOV:  result = operand_b;
      OP_BR:   if ((fmt & cc) != 3'b000) next_pc = br_target;
      OP_JMP:  next_pc = jmp_target;
      OP_JSR: begin
        result  = link_val;
        next_pc = br_target;
      end
      OP_JSRR: begin
        result  = link_val;
        next_pc = jmp_target;
      end
      default: ;
    endcase
  end

  always_comb begin
    cc_next = CC_Z;
    if ($signed(cc_value) < 0)
      cc_next = CC_N;
    else if (cc_value != '0)
      cc_next = CC_P;
  end

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle integer core: FETCH/DECODE/EXEC/MEM/WB sequencer, register file
// and request/acknowledge instruction and data memory ports.
module multicycle_datapath
  import multicycle_datapath_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int PC_WIDTH   = 16,
  parameter int RET_REG_ID = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lock,
  output logic                  imem_req,
  output logic [PC_WIDTH-3:0]   imem_addr,
  input  logic [31:0]           imem_rdata,
  input  logic                  imem_ack,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  retire,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic [2:0]            cc_out
);

  localparam int RIDX_W = $clog2(NUM_REGS);

  state_t                state_reg, state_next;
  logic [PC_WIDTH-1:0]   pc_reg;
  logic [PC_WIDTH-1:0]   next_pc_reg;
  logic [2:0]            cc_reg;
  logic                  fetch_pend_reg;
  logic [31:0]           ir_reg;
  logic [DATA_WIDTH-1:0] src1_reg, src2_reg, dst_val_reg;
  logic [DATA_WIDTH-1:0] result_reg, addr_reg;
  rf_wr_t                wr_reg, wr_dec;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   reg_we;

  logic [4:0]            opcode;
  logic [2:0]            fmt;
  logic [RIDX_W-1:0]     dst_idx, src1_idx, src2_idx;
  logic                  is_ld, is_st;
  logic [DATA_WIDTH-1:0] alu_result, alu_mem_addr;
  logic [PC_WIDTH-1:0]   alu_next_pc;
  logic [2:0]            wb_cc;
  logic                  unused_bits;

  assign opcode   = ir_reg[31:27];
  assign fmt      = ir_reg[26:24];
  assign dst_idx  = ir_reg[20 +: RIDX_W];
  assign src1_idx = ir_reg[16 +: RIDX_W];
  assign src2_idx = ir_reg[8 +: RIDX_W];
  assign is_ld    = (opcode == OP_LD);
  assign is_st    = (opcode == OP_ST);
  assign unused_bits = ^{ir_reg[23:16], wr_reg.idx};

  assign imem_addr  = pc_reg[PC_WIDTH-1:2];
  assign dmem_addr  = addr_reg;
  assign dmem_wdata = dst_val_reg;
  assign pc_out     = pc_reg;
  assign cc_out     = cc_reg;

  dp_alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .PC_WIDTH   (PC_WIDTH)
  ) u_alu (
    .opcode   (opcode),
    .fmt      (fmt),
    .src1_val (src1_reg),
    .src2_val (src2_reg),
    .imm      (ir_reg[15:0]),
    .pc       (pc_reg),
    .cc       (cc_reg),
    .cc_value (result_reg),
    .result   (alu_result),
    .mem_addr (alu_mem_addr),
    .next_pc  (alu_next_pc),
    .cc_next  (wb_cc)
  );

  // Once issued, a fetch is held by fetch_pend_reg so lock no longer matters
  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    retire     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        imem_req = !rst && (lock || fetch_pend_reg);
        if (imem_req && imem_ack) state_next = S_DECODE;
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC:   state_next = (is_ld || is_st) ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_st;
        if (dmem_ack) state_next = S_WB;
      end
      S_WB: begin
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    wr_dec = '0;
    case (opcode)
      OP_ADD, OP_AND, OP_MOV: begin
        if (fmt == FMT_IR || fmt == FMT_II) begin
          wr_dec.en     = 1'b1;
          wr_dec.set_cc = 1'b1;
          wr_dec.idx    = (opcode == OP_MOV) ? 4'(src1_idx) : 4'(dst_idx);
        end
      end
      OP_LD: begin
        wr_dec.en     = 1'b1;
        wr_dec.set_cc = 1'b1;
        wr_dec.idx    = 4'(dst_idx);
      end
      OP_JSR, OP_JSRR: begin
        wr_dec.en  = 1'b1;
        wr_dec.idx = 4'(RET_REG_ID);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_FETCH;
      pc_reg         <= '0;
      cc_reg         <= CC_Z;
      fetch_pend_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_FETCH)
        fetch_pend_reg <= imem_req && !imem_ack;
      if (state_reg == S_WB) begin
        pc_reg <= next_pc_reg;
        if (wr_reg.set_cc) cc_reg <= wb_cc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_reg == S_FETCH && imem_req && imem_ack)
      ir_reg <= imem_rdata;
    if (state_reg == S_DECODE) begin
      src1_reg    <= regs[src1_idx];
      src2_reg    <= regs[src2_idx];
      dst_val_reg <= regs[dst_idx];
    end
    if (state_reg == S_EXEC) begin
      result_reg  <= alu_result;
      addr_reg    <= alu_mem_addr;
      next_pc_reg <= alu_next_pc;
      wr_reg      <= wr_dec;
    end
    if (state_reg == S_MEM && dmem_ack && is_ld)
      result_reg <= dmem_rdata;
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_we
    assign reg_we[gi] = (state_reg == S_WB) && wr_reg.en &&
                        (wr_reg.idx[RIDX_W-1:0] == RIDX_W'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst)
        regs[i] <= '0;
      else if (reg_we[i])
        regs[i] <= result_reg;
    end
  end

endmodule
